des_key_schedule: RTL and testbench
===================================

Name: des_key_schedule

Overview:
Iterative DES key-schedule generator that produces the 16 48-bit round subkeys key1..key16 consumed by the pipelined DES datapath.
- Accepts one 64-bit key (parity bits ignored) on a start strobe.
- Derives one subkey per clock: PC-1, per-round left rotation of C/D, PC-2.
- Holds all 16 subkeys stable with a valid flag.
- Encrypt/decrypt subkey ordering is not this block's job; the DES datapath selects order with its own flag.

Parameters:
None. Permutation tables and the rotation schedule are fixed by FIPS 46-3.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  load key and begin generation; accepted only when not busy
key_in  input  [0:63]  DES key, bit 0 = FIPS bit 1 (MSB first); bits 7,15,...,63 are parity and ignored
busy  output  1  high while generating (GEN state)
key_valid  output  1  high when key1..key16 hold a complete schedule for the last accepted key
key1..key16  output  [0:47] each  round subkeys K1..K16, registered, bit 0 = FIPS bit 1

Behaviour:
- Reset (rst high at posedge): state=IDLE, C/D=0, round counter=0, key1..key16=0, busy=0, key_valid=0. Reset wins over start and aborts generation mid-run.
- States:
  - IDLE: no schedule held.
  - GEN: generating.
  - DONE: schedule held.
- Start accepted (posedge N), in IDLE or DONE with start=1:
  - {C,D} <= PC1(key_in) (56 bits).
  - cnt <= 0; state <= GEN.
  - key_valid <= 0; busy <= 1.
  - key_in is sampled only at this edge.
- GEN, each posedge, r = cnt (0..15):
  - {C,D} <= {rotl(C,s[r]), rotl(D,s[r])}, with s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - key(r+1) <= PC2(rotated {C,D}).
  - cnt <= cnt+1.
  - At r=15: state <= DONE, busy <= 0, key_valid <= 1.
- Latency: key_valid rises after edge N+16, so it is visible in the cycle following 16 GEN edges.
  - key(k) is written at edge N+k.
  - During GEN, subkeys not yet written are 0 on a run from IDLE, or keep their prior-run values on a run from DONE. Consumers must gate on key_valid.
- start=1 during GEN is ignored; no queuing. Generation continues for the original key.
- DONE: outputs held indefinitely. A new start restarts per the accepted-start rule.
- C/D after round 16 equals C0/D0 (total rotation 28). This is an invariant checked by assertion.
- Counter: 4 bits, no wrap beyond 15. Rotation amount is a lookup on cnt.
- No combinational path from any input to any output.

Test Plan:
1. FIPS worked example, key_in=133457799BBCDFF1, start pulse 1 cycle -> key_valid high exactly 16 cycles after accept. key1=1B02EFFC7072, key2=79AED9DBC9E5, key16=CB3D8B0E17F5. busy high for exactly 16 cycles.
2. Parity independence: key_in=123457799BBCDFF0 (133457799BBCDFF1 with parity bits 7 and 63 flipped) -> all 16 subkeys identical to scenario 1.
3. Start during GEN: accept 133457799BBCDFF1, then pulse start with key_in=0000000000000000 at cycle 5 -> ignored. Final schedule equals scenario 1; key_valid timing unchanged.
4. Restart from DONE: after scenario 1, start with key_in=0101010101010101 (weak key) -> key_valid drops the next cycle. After 16 cycles key1..key16 are all 000000000000; key_valid=1.
5. Reset mid-run: rst=1 at cycle 8 of GEN -> next cycle state IDLE, all subkeys 0, busy=0, key_valid=0. A subsequent start yields the correct schedule.
6. Back-to-back: start held high continuously with a fixed key -> regeneration every 17 cycles (16 GEN + 1 DONE accept edge). key_valid is high for 1 cycle per period; the value is always correct when high.

Source files
------------

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 on start, then one rotate + PC-2 round per
// clock, producing K1..K16 as registered outputs held until the next start.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [0:63] key_in,
    output logic        busy,
    output logic        key_valid,
    output logic [0:47] key1,
    output logic [0:47] key2,
    output logic [0:47] key3,
    output logic [0:47] key4,
    output logic [0:47] key5,
    output logic [0:47] key6,
    output logic [0:47] key7,
    output logic [0:47] key8,
    output logic [0:47] key9,
    output logic [0:47] key10,
    output logic [0:47] key11,
    output logic [0:47] key12,
    output logic [0:47] key13,
    output logic [0:47] key14,
    output logic [0:47] key15,
    output logic [0:47] key16
);

    // FIPS 46-3 tables, 1-based bit numbers with bit 1 = MSB.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Bit r set means round r+1 rotates by two; rounds 1, 2, 9 and 16 rotate by one.
    localparam logic [15:0] ROT2 = 16'h7EFC;

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [0:27] c_reg;
    logic [0:27] d_reg;
    logic [0:27] c_next;
    logic [0:27] d_next;
    logic [0:55] cd_next;
    logic [0:55] pc1_out;
    logic [0:47] pc2_out;
    logic [0:55] cd0_reg;
    logic        busy_reg;
    logic        valid_reg;
    logic [0:47] subkey_reg [16];

    // Parity bits never reach PC-1; gathered here only to mark them as intentionally dropped.
    logic unused_parity;
    assign unused_parity = ^{key_in[7], key_in[15], key_in[23], key_in[31],
                             key_in[39], key_in[47], key_in[55], key_in[63]};

    genvar gi;

    generate
        for (gi = 0; gi < 56; gi++) begin : g_pc1
            assign pc1_out[gi] = key_in[PC1[gi] - 1];
        end
    endgenerate

    // Rotate both halves left by the amount scheduled for the current round.
    always_comb begin
        c_next = {c_reg[1:27], c_reg[0]};
        d_next = {d_reg[1:27], d_reg[0]};
        if (ROT2[cnt_reg]) begin
            c_next = {c_reg[2:27], c_reg[0:1]};
            d_next = {d_reg[2:27], d_reg[0:1]};
        end
    end

    assign cd_next = {c_next, d_next};

    generate
        for (gi = 0; gi < 48; gi++) begin : g_pc2
            assign pc2_out[gi] = cd_next[PC2[gi] - 1];
        end
    endgenerate

    // Control FSM, C/D registers and subkey bank; reset clears everything and aborts a run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            c_reg     <= '0;
            d_reg     <= '0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                subkey_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        c_reg     <= pc1_out[0:27];
                        d_reg     <= pc1_out[28:55];
                        cnt_reg   <= 4'd0;
                        state_reg <= GEN;
                        busy_reg  <= 1'b1;
                        valid_reg <= 1'b0;
                    end
                end
                GEN: begin
                    c_reg               <= c_next;
                    d_reg               <= d_next;
                    subkey_reg[cnt_reg] <= pc2_out;
                    if (cnt_reg == 4'd15) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        valid_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Remember C0/D0 of the accepted key so the full-circle rotation can be checked.
    always_ff @(posedge clk) begin
        if (rst) begin
            cd0_reg <= '0;
        end else if (state_reg != GEN && start) begin
            cd0_reg <= pc1_out;
        end
    end

`ifndef SYNTHESIS
    // The 16 rotations sum to 28, so the last rotated C/D must equal C0/D0.
    always @(posedge clk) begin
        if (!rst && state_reg == GEN && cnt_reg == 4'd15) begin
            assert (cd_next == cd0_reg);
        end
    end
`endif

    assign busy      = busy_reg;
    assign key_valid = valid_reg;
    assign key1      = subkey_reg[0];
    assign key2      = subkey_reg[1];
    assign key3      = subkey_reg[2];
    assign key4      = subkey_reg[3];
    assign key5      = subkey_reg[4];
    assign key6      = subkey_reg[5];
    assign key7      = subkey_reg[6];
    assign key8      = subkey_reg[7];
    assign key9      = subkey_reg[8];
    assign key10     = subkey_reg[9];
    assign key11     = subkey_reg[10];
    assign key12     = subkey_reg[11];
    assign key13     = subkey_reg[12];
    assign key14     = subkey_reg[13];
    assign key15     = subkey_reg[14];
    assign key16     = subkey_reg[15];

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: vector table of keys with known
// schedules plus hand sequences for latency, ignored start, reset and restart.
module tb_des_key_schedule;

    logic        clk;
    logic        rst;
    logic        start;
    logic [0:63] key_in;
    logic        busy;
    logic        key_valid;
    logic [0:47] dut_key [16];

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [63:0]       key;
        logic [15:0][47:0] exp;
    } vec_t;

    vec_t        vec [4];
    logic [47:0] fips [16];

    des_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .key_valid(key_valid),
        .key1     (dut_key[0]),
        .key2     (dut_key[1]),
        .key3     (dut_key[2]),
        .key4     (dut_key[3]),
        .key5     (dut_key[4]),
        .key6     (dut_key[5]),
        .key7     (dut_key[6]),
        .key8     (dut_key[7]),
        .key9     (dut_key[8]),
        .key10    (dut_key[9]),
        .key11    (dut_key[10]),
        .key12    (dut_key[11]),
        .key13    (dut_key[12]),
        .key14    (dut_key[13]),
        .key15    (dut_key[14]),
        .key16    (dut_key[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Present key with a one-cycle start; returns at the negedge right after the accept edge.
    task automatic do_start(input logic [63:0] k);
        @(negedge clk);
        key_in = k;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // From the negedge after accept, count edges until key_valid and busy samples seen.
    task automatic wait_valid(output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = 0;
        while (!key_valid && cyc < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0][47:0] exp);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s key%0d", tag, i + 1), {16'h0, dut_key[i]}, {16'h0, exp[i]});
        end
    endtask

    initial begin
        int          cyc;
        int          bcnt;
        int          pulses;
        int          last_pulse;
        logic [15:0][47:0] fips_p;
        logic [15:0][47:0] zero_p;

        fips = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                 48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                 48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                 48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        for (int i = 0; i < 16; i++) begin
            fips_p[i] = fips[i];
            zero_p[i] = 48'h0;
        end
        vec[0].key = 64'h133457799BBCDFF1; vec[0].exp = fips_p;
        vec[1].key = 64'h123457799BBCDFF0; vec[1].exp = fips_p;
        vec[2].key = 64'h0101010101010101; vec[2].exp = zero_p;
        vec[3].key = 64'hFEFEFEFEFEFEFEFE;
        for (int i = 0; i < 16; i++) vec[3].exp[i] = 48'hFFFFFFFFFFFF;

        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy", {63'h0, busy}, 64'h0);
        check("reset key_valid", {63'h0, key_valid}, 64'h0);
        check("reset key1", {16'h0, dut_key[0]}, 64'h0);
        check("reset key16", {16'h0, dut_key[15]}, 64'h0);

        // Per-edge latency of the FIPS example from IDLE.
        do_start(64'h133457799BBCDFF1);
        check("lat c0 busy", {63'h0, busy}, 64'h1);
        check("lat c0 key1", {16'h0, dut_key[0]}, 64'h0);
        @(negedge clk);
        check("lat c1 key1", {16'h0, dut_key[0]}, {16'h0, fips[0]});
        check("lat c1 key2", {16'h0, dut_key[1]}, 64'h0);
        @(negedge clk);
        check("lat c2 key2", {16'h0, dut_key[1]}, {16'h0, fips[1]});
        wait_valid(cyc, bcnt);
        check("lat valid cycle", cyc + 2, 16);
        check("lat busy cycles", bcnt + 2, 16);
        check_all("lat", fips_p);
        repeat (3) @(negedge clk);
        check("hold key_valid", {63'h0, key_valid}, 64'h1);
        check("hold key16", {16'h0, dut_key[15]}, {16'h0, fips[15]});

        // Vector table; every run after the first restarts from DONE.
        for (int v = 0; v < 4; v++) begin
            do_start(vec[v].key);
            check($sformatf("v%0d valid drop", v), {63'h0, key_valid}, 64'h0);
            wait_valid(cyc, bcnt);
            check($sformatf("v%0d valid cycle", v), cyc, 16);
            check($sformatf("v%0d busy cycles", v), bcnt, 16);
            check($sformatf("v%0d valid", v), {63'h0, key_valid}, 64'h1);
            check_all($sformatf("v%0d", v), vec[v].exp);
        end

        // Start with an all-zero key during GEN must be ignored.
        do_start(64'h133457799BBCDFF1);
        cyc  = 0;
        while (!key_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 4) begin
                key_in = '0;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("ign valid cycle", cyc, 16);
        check_all("ign", fips_p);

        // Reset part-way through generation.
        do_start(64'hFEFEFEFEFEFEFEFE);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst busy", {63'h0, busy}, 64'h0);
        check("rst key_valid", {63'h0, key_valid}, 64'h0);
        check_all("rst", zero_p);
        do_start(64'h133457799BBCDFF1);
        wait_valid(cyc, bcnt);
        check("post-rst valid cycle", cyc, 16);
        check_all("post-rst", fips_p);

        // start held high: one-cycle valid pulse every 17 edges.
        @(negedge clk);
        key_in = 64'h133457799BBCDFF1;
        start  = 1'b1;
        pulses     = 0;
        last_pulse = -1;
        for (int c = 0; c < 56; c++) begin
            @(negedge clk);
            if (key_valid) begin
                pulses++;
                if (last_pulse < 0) begin
                    check("b2b first pulse", c, 16);
                end else begin
                    check("b2b period", c - last_pulse, 17);
                end
                last_pulse = c;
                check("b2b key1", {16'h0, dut_key[0]}, {16'h0, fips[0]});
                check("b2b key8", {16'h0, dut_key[7]}, {16'h0, fips[7]});
                check("b2b key16", {16'h0, dut_key[15]}, {16'h0, fips[15]});
            end
        end
        start = 1'b0;
        check("b2b pulse count", pulses, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
